// File: rtl/pwm_seq_pkg.sv
// Shared types and helpers for the PWM duty-cycle ramp sequencer.
// Holds the FSM and ramp-mode encodings, the duty width, and the
// clamped step arithmetic used on every dwell tick.
package pwm_seq_pkg;

    localparam int DUTY_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        UP_ONCE   = 2'b00,
        DOWN_ONCE = 2'b01,
        TRIANGLE  = 2'b10,
        SAW       = 2'b11
    } mode_e;

    // One ramp step in the requested direction, clamped to the limits.
    // The sum is formed one bit wider so a step past 0xFF is caught by the
    // clamp instead of wrapping; the difference is formed signed so a step
    // below zero is likewise caught by the lower clamp.
    function automatic logic [DUTY_W-1:0] nextDuty(
        input logic [DUTY_W-1:0] duty,
        input logic [DUTY_W-1:0] stepSize,
        input logic [DUTY_W-1:0] lo,
        input logic [DUTY_W-1:0] hi,
        input logic              up
    );
        logic        [DUTY_W:0]   sum;
        logic signed [DUTY_W+1:0] diff;
        logic signed [DUTY_W+1:0] loExt;
        sum   = {1'b0, duty} + {1'b0, stepSize};
        diff  = $signed({2'b00, duty}) - $signed({2'b00, stepSize});
        loExt = $signed({2'b00, lo});
        if (up) begin
            nextDuty = (sum > {1'b0, hi}) ? hi : sum[DUTY_W-1:0];
        end else begin
            nextDuty = (diff < loExt) ? lo : diff[DUTY_W-1:0];
        end
    endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Dwell timer for the ramp sequencer.
// A down-counter that fires a one-cycle tick every period+1 cycles while
// running. A load restarts the count from the supplied period so the first
// tick lands exactly period+1 cycles after the load edge.
module ramp_tick_gen #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               run,
    input  logic [DWELL_W-1:0] period,
    output logic               tick
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    // A load always wins over a tick so a restart never produces a stray update.
    assign tick = run && !load && (cnt_q == '0);

    // Next count: reload on load or on expiry, otherwise count down while running.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = period;
        end else if (run) begin
            if (cnt_q == '0) begin
                cnt_d = period;
            end else begin
                cnt_d = cnt_q - DWELL_W'(1);
            end
        end
    end

    // Dwell counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Autonomous duty-cycle sequencer between the SPI register file and the PWM.
// With ramp_en low the SPI duty is passed through one register stage; with
// ramp_en high a start pulse latches the ramp configuration and the duty is
// stepped between the latched limits on every dwell tick, either once
// (up or down, ending in HOLD with a done pulse) or continuously
// (triangle or sawtooth).
module pwm_ramp_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ramp_en,
    input  logic               start,
    input  logic [1:0]         ramp_mode,
    input  logic [7:0]         step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         lo_lim,
    input  logic [7:0]         hi_lim,
    input  logic [7:0]         spi_duty,
    output logic [7:0]         duty_out,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    // FSM and output registers
    state_e              state_q, state_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                up_q, up_d;

    // Configuration captured on an accepted start
    mode_e               mode_q, mode_d;
    logic [DUTY_W-1:0]   stepCfg_q, stepCfg_d;
    logic [DUTY_W-1:0]   lo_q, lo_d;
    logic [DUTY_W-1:0]   hi_q, hi_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;

    logic                startOk;
    logic                tickLoad;
    logic                tickRun;
    logic [DWELL_W-1:0]  tickPeriod;
    logic                tick;
    logic [DUTY_W-1:0]   nxtDuty;

    // A start is only honoured with ordered limits; ramp_en low overrides it.
    assign startOk    = start && (lo_lim <= hi_lim);
    assign tickLoad   = ramp_en && startOk;
    assign tickRun    = (state_q == RUN);
    // On the load edge the latched dwell is not yet valid, so feed the live input.
    assign tickPeriod = tickLoad ? dwell : dwell_q;

    // Candidate next duty for the current direction using the latched config.
    assign nxtDuty = nextDuty(duty_q, stepCfg_q, lo_q, hi_q, up_q);

    ramp_tick_gen #(
        .DWELL_W (DWELL_W)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tickLoad),
        .run    (tickRun),
        .period (tickPeriod),
        .tick   (tick)
    );

    // Next-state, next-duty and pulse-output decode for the sequencer FSM.
    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        up_d      = up_q;
        mode_d    = mode_q;
        stepCfg_d = stepCfg_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        dwell_d   = dwell_q;

        if (!ramp_en) begin
            state_d = IDLE;
            duty_d  = spi_duty;
            busy_d  = 1'b0;
        end else begin
            if (start && !startOk) begin
                err_d = 1'b1;
            end

            if (startOk) begin
                mode_d    = mode_e'(ramp_mode);
                stepCfg_d = (step == '0) ? DUTY_W'(1) : step;
                lo_d      = lo_lim;
                hi_d      = hi_lim;
                dwell_d   = dwell;
                state_d   = RUN;
                busy_d    = 1'b1;
                if (ramp_mode == DOWN_ONCE) begin
                    duty_d = hi_lim;
                    up_d   = 1'b0;
                end else begin
                    duty_d = lo_lim;
                    up_d   = 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        duty_d = spi_duty;
                    end
                    RUN: begin
                        if (tick) begin
                            case (mode_q)
                                UP_ONCE: begin
                                    duty_d = nxtDuty;
                                    if (nxtDuty == hi_q) begin
                                        state_d = HOLD;
                                        busy_d  = 1'b0;
                                        done_d  = 1'b1;
                                    end
                                end
                                DOWN_ONCE: begin
                                    duty_d = nxtDuty;
                                    if (nxtDuty == lo_q) begin
                                        state_d = HOLD;
                                        busy_d  = 1'b0;
                                        done_d  = 1'b1;
                                    end
                                end
                                TRIANGLE: begin
                                    duty_d = nxtDuty;
                                    if (up_q && (nxtDuty == hi_q)) begin
                                        up_d = 1'b0;
                                    end else if (!up_q && (nxtDuty == lo_q)) begin
                                        up_d = 1'b1;
                                    end
                                end
                                SAW: begin
                                    duty_d = (duty_q == hi_q) ? lo_q : nxtDuty;
                                end
                            endcase
                        end
                    end
                    HOLD: begin
                        duty_d = duty_q;
                    end
                    default: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                endcase
            end
        end
    end

    // State, registered outputs and latched configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            duty_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            up_q      <= 1'b1;
            mode_q    <= UP_ONCE;
            stepCfg_q <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            up_q      <= up_d;
            mode_q    <= mode_d;
            stepCfg_q <= stepCfg_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            dwell_q   <= dwell_d;
        end
    end

    assign duty_out = duty_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer: a short vector table, hand
// sequences for the multi-cycle ramp cases, then randomized traffic compared
// against a behavioural model of the sequencer.
module tb_pwm_ramp_sequencer;

    typedef struct {
        logic        en;
        logic        st;
        logic [1:0]  mode;
        logic [7:0]  stp;
        logic [15:0] dwl;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [7:0]  spi;
        logic [7:0]  eDuty;
        logic        eBusy;
        logic        eDone;
        logic        eErr;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        ramp_en;
    logic        start;
    logic [1:0]  ramp_mode;
    logic [7:0]  step;
    logic [15:0] dwell;
    logic [7:0]  lo_lim;
    logic [7:0]  hi_lim;
    logic [7:0]  spi_duty;
    logic [7:0]  duty_out;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int vectors;
    int miscompares;

    // Behavioural model state
    int mState;
    int mDuty;
    int mMode;
    int mStep;
    int mDwell;
    int mLo;
    int mHi;
    int mCyc;
    bit mUp;
    bit mBusy;
    bit mDone;
    bit mErr;

    vec_t vecs[9];

    pwm_ramp_sequencer #(
        .DWELL_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ramp_en   (ramp_en),
        .start     (start),
        .ramp_mode (ramp_mode),
        .step      (step),
        .dwell     (dwell),
        .lo_lim    (lo_lim),
        .hi_lim    (hi_lim),
        .spi_duty  (spi_duty),
        .duty_out  (duty_out),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        ramp_en   = v.en;
        start     = v.st;
        ramp_mode = v.mode;
        step      = v.stp;
        dwell     = v.dwl;
        lo_lim    = v.lo;
        hi_lim    = v.hi;
        spi_duty  = v.spi;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eDuty,
                               input logic eBusy, input logic eDone, input logic eErr);
        vectors++;
        if (duty_out !== eDuty || busy !== eBusy || done !== eDone || cfg_err !== eErr) begin
            miscompares++;
            $display("[TB] FAIL %s: got duty=%02h busy=%0b done=%0b cfg_err=%0b, expected duty=%02h busy=%0b done=%0b cfg_err=%0b",
                     name, duty_out, busy, done, cfg_err, eDuty, eBusy, eDone, eErr);
        end
    endtask

    task automatic setCfg(input logic [1:0] m, input logic [7:0] s, input logic [15:0] d,
                          input logic [7:0] lo, input logic [7:0] hi);
        ramp_mode = m;
        step      = s;
        dwell     = d;
        lo_lim    = lo;
        hi_lim    = hi;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        stepClk();
        start = 1'b0;
    endtask

    task automatic modelReset();
        mState = 0;
        mDuty  = 0;
        mUp    = 1'b1;
        mBusy  = 1'b0;
        mDone  = 1'b0;
        mErr   = 1'b0;
        mCyc   = 0;
    endtask

    // Predict the outputs after the coming edge from the current inputs.
    // Ticks are counted as cycles elapsed since the start edge.
    task automatic modelStep();
        int nxt;
        mDone = 1'b0;
        mErr  = 1'b0;
        if (!ramp_en) begin
            mState = 0;
            mDuty  = spi_duty;
            mBusy  = 1'b0;
            return;
        end
        if (start && lo_lim > hi_lim) mErr = 1'b1;
        if (start && lo_lim <= hi_lim) begin
            mMode  = ramp_mode;
            mStep  = (step == 0) ? 1 : step;
            mDwell = dwell;
            mLo    = lo_lim;
            mHi    = hi_lim;
            mCyc   = 0;
            mUp    = (ramp_mode != 2'd1);
            mDuty  = (ramp_mode == 2'd1) ? mHi : mLo;
            mState = 1;
            mBusy  = 1'b1;
        end else if (mState == 0) begin
            mDuty = spi_duty;
        end else if (mState == 1) begin
            mCyc++;
            if (mCyc % (mDwell + 1) == 0) begin
                nxt = mUp ? mDuty + mStep : mDuty - mStep;
                if (nxt > mHi) nxt = mHi;
                if (nxt < mLo) nxt = mLo;
                case (mMode)
                    0, 1: begin
                        mDuty = nxt;
                        if ((mMode == 0 && nxt == mHi) || (mMode == 1 && nxt == mLo)) begin
                            mState = 2;
                            mBusy  = 1'b0;
                            mDone  = 1'b1;
                        end
                    end
                    2: begin
                        mDuty = nxt;
                        if (nxt == mHi) mUp = 1'b0;
                        else if (nxt == mLo) mUp = 1'b1;
                    end
                    default: begin
                        mDuty = (mDuty == mHi) ? mLo : nxt;
                    end
                endcase
            end
        end
    endtask

    initial begin
        logic [7:0] triExp[6];
        logic [7:0] sawExp[6];
        int tmp;
        int r;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        ramp_en     = 1'b0;
        start       = 1'b0;
        setCfg(2'd0, 8'h00, 16'd0, 8'h00, 8'h00);
        spi_duty    = 8'h5A;

        // Table: IDLE pass-through, clamped one-shot down, rejected start in HOLD, drop enable
        vecs[0] = '{1'b1, 1'b0, 2'd0, 8'h00, 16'd0, 8'h00, 8'h00, 8'h77, 8'h77, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 2'd1, 8'h0C, 16'd0, 8'h05, 8'h20, 8'h77, 8'h20, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 2'd0, 8'h01, 16'd5, 8'h00, 8'hFF, 8'h99, 8'h14, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 2'd0, 8'h01, 16'd5, 8'h00, 8'hFF, 8'h99, 8'h08, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 2'd0, 8'h01, 16'd5, 8'h00, 8'hFF, 8'h99, 8'h05, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 2'd0, 8'h01, 16'd5, 8'h00, 8'hFF, 8'h99, 8'h05, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 2'd0, 8'h01, 16'd0, 8'h30, 8'h20, 8'h99, 8'h05, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 2'd0, 8'h01, 16'd0, 8'h30, 8'h20, 8'h99, 8'h05, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 2'd0, 8'h01, 16'd0, 8'h30, 8'h20, 8'h33, 8'h33, 1'b0, 1'b0, 1'b0};

        triExp = '{8'hFE, 8'hFF, 8'hFE, 8'hFD, 8'hFE, 8'hFF};
        sawExp = '{8'h02, 8'h03, 8'h00, 8'h02, 8'h03, 8'h00};

        // Reset and pass-through latency
        #12;
        checkOutput("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        stepClk();
        checkOutput("passthru", 8'h5A, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            stepClk();
            checkOutput($sformatf("vec%0d", i), vecs[i].eDuty, vecs[i].eBusy,
                        vecs[i].eDone, vecs[i].eErr);
        end
        start = 1'b0;

        // One-shot up with dwell 3; inputs are scrambled after start to prove latching
        ramp_en = 1'b1;
        setCfg(2'd0, 8'h10, 16'd3, 8'h10, 8'h40);
        pulseStart();
        checkOutput("up_start", 8'h10, 1'b1, 1'b0, 1'b0);
        setCfg(2'd1, 8'h01, 16'd0, 8'h00, 8'hFF);
        for (int i = 1; i <= 14; i++) begin
            stepClk();
            tmp = 16 + 16 * (i / 4);
            if (tmp > 64) tmp = 64;
            checkOutput($sformatf("up_cyc%0d", i), 8'(tmp), (i < 12), (i == 12), 1'b0);
        end

        // Triangle at the top of the range with step 0 treated as 1
        setCfg(2'd2, 8'h00, 16'd0, 8'hFD, 8'hFF);
        pulseStart();
        checkOutput("tri_start", 8'hFD, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            stepClk();
            checkOutput($sformatf("tri%0d", i), triExp[i], 1'b1, 1'b0, 1'b0);
        end

        // Sawtooth, started as a restart while the triangle is running
        setCfg(2'd3, 8'h02, 16'd0, 8'h00, 8'h03);
        pulseStart();
        checkOutput("saw_start", 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            stepClk();
            checkOutput($sformatf("saw%0d", i), sawExp[i], 1'b1, 1'b0, 1'b0);
        end

        // Rejected start from IDLE
        ramp_en  = 1'b0;
        spi_duty = 8'h11;
        stepClk();
        checkOutput("to_idle", 8'h11, 1'b0, 1'b0, 1'b0);
        ramp_en = 1'b1;
        setCfg(2'd0, 8'h01, 16'd0, 8'h30, 8'h20);
        pulseStart();
        checkOutput("cfg_err_pulse", 8'h11, 1'b0, 1'b0, 1'b1);
        stepClk();
        checkOutput("cfg_err_clear", 8'h11, 1'b0, 1'b0, 1'b0);

        // Enable dropped mid-ramp
        setCfg(2'd0, 8'h01, 16'd0, 8'h00, 8'hFF);
        pulseStart();
        checkOutput("drop_start", 8'h00, 1'b1, 1'b0, 1'b0);
        stepClk();
        stepClk();
        checkOutput("drop_run", 8'h02, 1'b1, 1'b0, 1'b0);
        ramp_en  = 1'b0;
        spi_duty = 8'hA5;
        stepClk();
        checkOutput("drop_idle", 8'hA5, 1'b0, 1'b0, 1'b0);
        spi_duty = 8'h3C;
        stepClk();
        checkOutput("drop_follow", 8'h3C, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-ramp
        ramp_en = 1'b1;
        setCfg(2'd2, 8'h05, 16'd0, 8'h10, 8'h80);
        pulseStart();
        stepClk();
        stepClk();
        checkOutput("rst_run", 8'h1A, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        checkOutput("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        spi_duty = 8'h42;
        stepClk();
        checkOutput("post_reset", 8'h42, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model
        modelReset();
        for (int i = 0; i < 2500; i++) begin
            ramp_en   = ($urandom_range(0, 49) != 0);
            start     = ($urandom_range(0, 29) == 0);
            ramp_mode = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r == 0) step = 8'h00;
            else if (r == 1) step = 8'hFF;
            else step = 8'($urandom_range(1, 24));
            dwell  = 16'($urandom_range(0, 3));
            lo_lim = 8'($urandom_range(0, 255));
            tmp = lo_lim + $urandom_range(0, 48);
            if (tmp > 255) tmp = 255;
            hi_lim = 8'(tmp);
            if ($urandom_range(0, 9) == 0) begin
                tmp    = lo_lim;
                lo_lim = hi_lim;
                hi_lim = 8'(tmp);
            end
            spi_duty = 8'($urandom_range(0, 255));
            modelStep();
            stepClk();
            checkOutput("random", 8'(mDuty), mBusy, mDone, mErr);
        end
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
